// File: rtl/keypad_scan_port.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scan_port
//  Description : Memory-mapped responder for a 4x4 matrix keypad on the CPU
//                data bus. Drives one row low at a time, debounces a closed
//                key, and latches its 4-bit code with a ready flag. The CPU
//                polls status at BASE_ADDR, reads the code at BASE_ADDR+1,
//                and writes BASE_ADDR to acknowledge.
//
//  Ports       : clk       in   1   system clock, all logic on posedge
//                reset     in   1   synchronous, active-high reset
//                rowwrite  out  4   row drive, active-low, one bit low
//                colread   in   4   column sense, active-low, asynchronous
//                address   in   12  CPU address
//                memwt     in   1   CPU write strobe
//                dataout   out  16  read data for current address (comb.)
//                irq       out  1   ready-rise pulse (KEYPAD_IRQ_EN only)
//
//  Options     : KEYPAD_IRQ_EN - when defined, adds the irq output, a
//                one-clock pulse on the clock where ready goes 0->1.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_port #(
    parameter logic [11:0] BASE_ADDR      = 12'h900,
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [3:0]  rowwrite,
    input  logic [3:0]  colread,
    input  logic [11:0] address,
    input  logic        memwt,
    output logic [15:0] dataout
`ifdef KEYPAD_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [TICK_W-1:0] c_tick_last   = TICK_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  c_scans       = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0]  c_one         = CNT_W'(1);
    localparam logic [11:0]       c_addr_status = BASE_ADDR;
    localparam logic [11:0]       c_addr_data   = BASE_ADDR + 12'd1;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_col_meta;
    logic [3:0]         r_col_sync;
    logic [TICK_W-1:0]  r_tick_cnt;
    logic [1:0]         r_row_idx;
    logic [1:0]         w_row_nxt;
    logic [1:0]         r_col_idx;
    logic [1:0]         w_col_nxt;
    logic [CNT_W-1:0]   r_deb_cnt;
    logic [CNT_W-1:0]   w_deb_nxt;
    logic [CNT_W-1:0]   w_deb_inc;
    logic [CNT_W-1:0]   r_rel_cnt;
    logic [CNT_W-1:0]   w_rel_nxt;
    logic [CNT_W-1:0]   w_rel_inc;
    logic [3:0]         r_code;
    logic               r_ready;
    logic               r_overrun;
    logic               w_tick;
    logic               w_key_any;
    logic               w_col_held;
    logic [1:0]         w_col_enc;
    logic               w_latch;
    logic [3:0]         w_new_code;
    logic               w_ack;

    // Two-flop synchronizer for the asynchronous column inputs; idle is all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col_meta <= 4'hF;
            r_col_sync <= 4'hF;
        end else begin
            r_col_meta <= colread;
            r_col_sync <= r_col_meta;
        end
    end

    // Scan tick prescaler.
    assign w_tick = (r_tick_cnt == c_tick_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Lowest closed column wins when several read low at once.
    always_comb begin
        w_col_enc = 2'd0;
        if (!r_col_sync[0]) begin
            w_col_enc = 2'd0;
        end else if (!r_col_sync[1]) begin
            w_col_enc = 2'd1;
        end else if (!r_col_sync[2]) begin
            w_col_enc = 2'd2;
        end else if (!r_col_sync[3]) begin
            w_col_enc = 2'd3;
        end
    end

    assign w_key_any  = (r_col_sync != 4'hF);
    assign w_col_held = ~r_col_sync[r_col_idx];
    assign w_deb_inc  = (r_deb_cnt == c_scans) ? c_scans : (r_deb_cnt + c_one);
    assign w_rel_inc  = (r_rel_cnt == c_scans) ? c_scans : (r_rel_cnt + c_one);

    // Next-state logic: nothing moves except on scan ticks.
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row_idx;
        w_col_nxt   = r_col_idx;
        w_deb_nxt   = r_deb_cnt;
        w_rel_nxt   = r_rel_cnt;
        w_latch     = 1'b0;
        w_new_code  = {r_row_idx, r_col_idx};
        if (w_tick) begin
            case (r_state)
                ST_SCAN: begin
                    if (w_key_any) begin
                        w_col_nxt  = w_col_enc;
                        w_deb_nxt  = c_one;
                        w_new_code = {r_row_idx, w_col_enc};
                        // With a single-sample debounce the detecting tick
                        // is also the confirming one.
                        if (DEBOUNCE_SCANS == 1) begin
                            w_latch     = 1'b1;
                            w_rel_nxt   = '0;
                            w_state_nxt = ST_HELD;
                        end else begin
                            w_state_nxt = ST_DEBOUNCE;
                        end
                    end else begin
                        w_row_nxt = r_row_idx + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_col_held) begin
                        w_deb_nxt = w_deb_inc;
                        if (w_deb_inc == c_scans) begin
                            w_latch     = 1'b1;
                            w_rel_nxt   = '0;
                            w_state_nxt = ST_HELD;
                        end
                    end else begin
                        w_deb_nxt   = '0;
                        w_row_nxt   = r_row_idx + 2'd1;
                        w_state_nxt = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    // Any closed column on the held row restarts release timing.
                    if (!w_key_any) begin
                        w_rel_nxt = w_rel_inc;
                        if (w_rel_inc == c_scans) begin
                            w_rel_nxt   = '0;
                            w_deb_nxt   = '0;
                            w_row_nxt   = r_row_idx + 2'd1;
                            w_state_nxt = ST_SCAN;
                        end
                    end else begin
                        w_rel_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_SCAN;
            r_row_idx <= 2'd0;
            r_col_idx <= 2'd0;
            r_deb_cnt <= '0;
            r_rel_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_row_idx <= w_row_nxt;
            r_col_idx <= w_col_nxt;
            r_deb_cnt <= w_deb_nxt;
            r_rel_cnt <= w_rel_nxt;
        end
    end

    // Key register. An acknowledge arriving with a new key consumes the
    // old key, so the new one lands cleanly with no overrun.
    assign w_ack = memwt && (address == c_addr_status);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_code    <= 4'h0;
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_latch && w_ack) begin
            r_code    <= w_new_code;
            r_ready   <= 1'b1;
            r_overrun <= 1'b0;
        end else if (w_latch) begin
            if (!r_ready) begin
                r_code  <= w_new_code;
                r_ready <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (w_ack) begin
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

`ifdef KEYPAD_IRQ_EN
    logic r_irq;

    // Fires only on a genuine 0->1 of ready, aligned with the ready register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_latch && !r_ready;
        end
    end

    assign irq = r_irq;
`endif

    assign rowwrite = ~(4'b0001 << r_row_idx);

    always_comb begin
        dataout = 16'h0000;
        if (address == c_addr_status) begin
            dataout = {14'b0, r_overrun, r_ready};
        end else if (address == c_addr_data) begin
            dataout = {12'h000, r_code};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scan_port
//  Description : Self-checking bench for keypad_scan_port with SCAN_DIV=4,
//                DEBOUNCE_SCANS=2, BASE_ADDR=12'h900. A behavioural keypad
//                closes one key onto the column lines whenever its row is
//                driven low. Honours KEYPAD_IRQ_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_port;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic [3:0]  rowwrite;
    logic [3:0]  colread;
    logic [11:0] address  = 12'h000;
    logic        memwt    = 1'b0;
    logic [15:0] dataout;
`ifdef KEYPAD_IRQ_EN
    logic        irq;
`endif

    logic        key_down = 1'b0;
    logic [1:0]  key_row  = 2'd0;
    logic [1:0]  key_col  = 2'd0;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int irq_cnt = 0;

    typedef struct {
        logic [11:0] addr;
        logic [15:0] exp;
    } rd_vec_t;

    rd_vec_t tbl [8];

    keypad_scan_port #(
        .BASE_ADDR      (12'h900),
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rowwrite (rowwrite),
        .colread  (colread),
        .address  (address),
        .memwt    (memwt),
        .dataout  (dataout)
`ifdef KEYPAD_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    // Keypad model: the pressed key pulls its column low while its row is driven.
    assign colread = (key_down && (rowwrite[key_row] == 1'b0)) ? ~(4'b0001 << key_col) : 4'hF;

`ifdef KEYPAD_IRQ_EN
    always @(negedge clk) begin
        if (irq === 1'b1) irq_cnt = irq_cnt + 1;
    end
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_rd(input string name, input logic [11:0] a, input logic [15:0] exp);
        address = a;
        #1;
        check(name, dataout, exp);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        memwt   = 1'b0;
        address = 12'h000;
        repeat (3) step();
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic wait_ready(input string name, input int max_cycles);
        logic ok;
        ok = 1'b0;
        address = 12'h900;
        for (int i = 0; i < max_cycles; i++) begin
            #1;
            if (dataout[0] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check(name, {15'b0, ok}, 16'h0001);
    endtask

    initial begin
        logic [3:0] one4;
        logic [3:0] exp_rw;
        int         irq_base;

        tbl[0] = '{12'h900, 16'h0001};
        tbl[1] = '{12'h901, 16'h0009};
        tbl[2] = '{12'h000, 16'h0000};
        tbl[3] = '{12'h8FF, 16'h0000};
        tbl[4] = '{12'h902, 16'h0000};
        tbl[5] = '{12'h801, 16'h0000};
        tbl[6] = '{12'h901, 16'h0009};
        tbl[7] = '{12'h900, 16'h0001};

        one4 = 4'b0001;

        // ---- Reset state and free-running row scan with no keys ----
        key_down = 1'b0;
        do_reset();
        check("reset_rowwrite", {12'h000, rowwrite}, 16'h000E);
        chk_rd("reset_status", 12'h900, 16'h0000);
        chk_rd("reset_code", 12'h901, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            step();
            exp_rw = ~(one4 << ((cyc / 4) % 4));
            check("scan_rowwrite", {12'h000, rowwrite}, {12'h000, exp_rw});
        end

        // ---- Steady row2/col1 press: latency, read map, acknowledge ----
        key_row  = 2'd2;
        key_col  = 2'd1;
        key_down = 1'b1;
        do_reset();
        address = 12'h900;
        while (cyc < 15) step();
        chk_rd("latency_before", 12'h900, 16'h0000);
        step();
        chk_rd("latency_ready", 12'h900, 16'h0001);
        for (int i = 0; i < 8; i++) begin
            chk_rd($sformatf("readmap[%0d] addr=%h", i, tbl[i].addr), tbl[i].addr, tbl[i].exp);
        end
        address = 12'h900;
        memwt   = 1'b1;
        step();
        memwt = 1'b0;
        chk_rd("ack_status", 12'h900, 16'h0000);
        chk_rd("ack_code_kept", 12'h901, 16'h0009);
        repeat (12) step();
        chk_rd("held_no_repeat", 12'h900, 16'h0000);

        // ---- One-tick glitch on row1/col3 ----
        key_down = 1'b0;
        key_row  = 2'd1;
        key_col  = 2'd3;
        do_reset();
        while (cyc < 4) step();
        key_down = 1'b1;
        while (cyc < 9) step();
        key_down = 1'b0;
        while (cyc < 11) step();
        check("glitch_row_held", {12'h000, rowwrite}, 16'h000D);
        step();
        check("glitch_row_next", {12'h000, rowwrite}, 16'h000B);
        chk_rd("glitch_status", 12'h900, 16'h0000);
        repeat (20) step();
        chk_rd("glitch_status_late", 12'h900, 16'h0000);

        // ---- Press 5, release, press A without acknowledge -> overrun ----
        key_down = 1'b0;
        do_reset();
        irq_base = irq_cnt;
        key_row  = 2'd1;
        key_col  = 2'd1;
        key_down = 1'b1;
        wait_ready("key5_ready_timeout", 60);
        chk_rd("key5_code", 12'h901, 16'h0005);
        chk_rd("key5_status", 12'h900, 16'h0001);
        key_down = 1'b0;
        repeat (24) step();
        key_row  = 2'd2;
        key_col  = 2'd2;
        key_down = 1'b1;
        repeat (60) step();
        chk_rd("overrun_status", 12'h900, 16'h0003);
        chk_rd("overrun_code_kept", 12'h901, 16'h0005);
`ifdef KEYPAD_IRQ_EN
        check("irq_single_on_overrun", 16'(irq_cnt - irq_base), 16'd1);
`endif

        // ---- Latch coinciding with acknowledge ----
        key_down = 1'b0;
        do_reset();
        irq_base = irq_cnt;
        key_row  = 2'd1;
        key_col  = 2'd1;
        key_down = 1'b1;
        address  = 12'h900;
        while (cyc < 11) step();
        chk_rd("first_latch_before", 12'h900, 16'h0000);
        step();
        chk_rd("first_latch_ready", 12'h900, 16'h0001);
        // Swap to key 9 while row1 is held: row1 reads released.
        key_row = 2'd2;
        key_col = 2'd1;
        while (cyc < 27) step();
        address = 12'h900;
        memwt   = 1'b1;
        step();
        memwt = 1'b0;
        chk_rd("coincide_status", 12'h900, 16'h0001);
        chk_rd("coincide_code", 12'h901, 16'h0009);
`ifdef KEYPAD_IRQ_EN
        check("irq_count_coincide", 16'(irq_cnt - irq_base), 16'd1);
`endif

        // ---- Reset while held, then fresh re-detection ----
        reset = 1'b1;
        step();
        check("rst_held_rowwrite", {12'h000, rowwrite}, 16'h000E);
        chk_rd("rst_held_status", 12'h900, 16'h0000);
        chk_rd("rst_held_code", 12'h901, 16'h0000);
`ifdef KEYPAD_IRQ_EN
        check("rst_held_irq", {15'b0, irq}, 16'h0000);
`endif
        reset = 1'b0;
        cyc   = 0;
        wait_ready("redetect_timeout", 40);
        chk_rd("redetect_code", 12'h901, 16'h0009);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
